// File: rtl/bomb_sequencer.sv
// Fuse/explosion sequencer for two bomb1 channels sharing one map RAM read port.
// A single scan engine walks centre/left/right/above/below for the granted channel.
module bomb_sequencer #(
    parameter int unsigned FUSE_FRAMES  = 120,
    parameter int unsigned BLAST_FRAMES = 30,
    parameter int unsigned MAP_W        = 20,
    parameter int unsigned MAP_H        = 15,
    parameter logic [3:0]  WALL_CODE    = 4'd1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       bomb_check0,
    input  logic       bomb_check1,
    input  logic [9:0] bombX0,
    input  logic [9:0] bombX1,
    input  logic [9:0] bombY0,
    input  logic [9:0] bombY1,
    input  logic [3:0] map_q,
    output logic [3:0] bomb_state0,
    output logic [3:0] bomb_state1,
    output logic [9:0] map_addr,
    output logic       map_rden,
    output logic [4:0] blast_mask0,
    output logic [4:0] blast_mask1,
    output logic       explode0,
    output logic       explode1
);

    localparam int unsigned CNT_MAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FUSE, S_SCAN_REQ, S_SCAN, S_EXPLODE, S_DONE
    } state_e;

    logic          check  [2];
    logic [4:0]    cx     [2];
    logic [4:0]    cy     [2];
    logic [9:0]    centre [2];
    logic [4:0]    blk    [2];

    state_e        state_q [2], state_d [2];
    logic [CW-1:0] cnt_q   [2], cnt_d   [2];
    logic [4:0]    mask_q  [2], mask_d  [2];
    logic          abort_q [2], abort_d [2];
    logic [3:0]    code_q  [2];
    logic          explode_q [2];

    logic       eng_active_q, eng_active_d;
    logic       eng_owner_q,  eng_owner_d;
    logic [2:0] eng_step_q,   eng_step_d;
    logic [9:0] eng_c_q,      eng_c_d;
    logic [4:0] eng_blk_q,    eng_blk_d;
    logic [3:1] eng_acc_q,    eng_acc_d;
    logic [9:0] addr_q,       addr_d;
    logic       rden_q,       rden_d;
    logic       ptr_q,        ptr_d;

    logic       req [2];
    logic       chain [2];
    logic       eng_free, grant_valid, grant_ch, scan_last, cap_bit;
    logic [2:0] slot;
    logic [4:0] final_mask;
    logic       unused_lsb;

    assign check[0] = bomb_check0;
    assign check[1] = bomb_check1;
    assign cx[0]    = bombX0[9:5];
    assign cx[1]    = bombX1[9:5];
    assign cy[0]    = bombY0[9:5];
    assign cy[1]    = bombY1[9:5];
    assign unused_lsb = ^{bombX0[4:0], bombX1[4:0], bombY0[4:0], bombY1[4:0]};

    function automatic logic [9:0] slot_addr(input logic [9:0] c, input logic [2:0] k);
        case (k)
            3'd1:    return c - 10'd1;
            3'd2:    return c + 10'd1;
            3'd3:    return c - 10'(MAP_W);
            3'd4:    return c + 10'(MAP_W);
            default: return c;
        endcase
    endfunction

    // Neighbour compares are done one bit wider so tile 0 never aliases the far edge.
    function automatic logic covers(input logic [4:0] m, input logic [4:0] ax, input logic [4:0] ay,
                                    input logic [4:0] bx, input logic [4:0] by);
        return (bx == ax && by == ay)
            || (m[1] && by == ay && 6'(bx) + 6'd1 == 6'(ax))
            || (m[2] && by == ay && 6'(bx) == 6'(ax) + 6'd1)
            || (m[3] && bx == ax && 6'(by) + 6'd1 == 6'(ay))
            || (m[4] && bx == ax && 6'(by) == 6'(ay) + 6'd1);
    endfunction

    function automatic logic [3:0] state_code(input state_e s);
        case (s)
            S_FUSE:               return 4'b0001;
            S_SCAN_REQ, S_SCAN:   return 4'b0010;
            S_EXPLODE:            return 4'b0011;
            S_DONE:               return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            centre[i] = 10'(cy[i]) * 10'(MAP_W) + 10'(cx[i]);
            blk[i]    = {cy[i] == 5'(MAP_H - 1), cy[i] == 5'd0, cx[i] == 5'(MAP_W - 1), cx[i] == 5'd0, 1'b0};
            req[i]    = (state_q[i] == S_SCAN_REQ) && check[i];
        end
        chain[0] = (state_q[1] == S_EXPLODE) && covers(mask_q[1], cx[1], cy[1], cx[0], cy[0]);
        chain[1] = (state_q[0] == S_EXPLODE) && covers(mask_q[0], cx[0], cy[0], cx[1], cy[1]);

        // The port frees up during the owner's final capture cycle so the next scan starts back-to-back.
        scan_last   = eng_active_q && (eng_step_q == 3'd5);
        eng_free    = !eng_active_q || scan_last;
        grant_valid = eng_free && (req[0] || req[1]);
        grant_ch    = (req[0] && req[1]) ? ptr_q : req[1];

        slot       = eng_step_q - 3'd1;
        cap_bit    = (eng_step_q != 3'd0) && !eng_blk_q[slot] && (map_q != WALL_CODE);
        final_mask = {cap_bit, eng_acc_q, 1'b1};
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            mask_d[i]  = mask_q[i];
            abort_d[i] = abort_q[i];
            case (state_q[i])
                S_IDLE: if (check[i]) begin
                    state_d[i] = S_FUSE;
                    cnt_d[i]   = CW'(FUSE_FRAMES - 1);
                end
                S_FUSE: begin
                    if (!check[i])                          state_d[i] = S_IDLE;
                    else if (cnt_q[i] == '0 || chain[i])    state_d[i] = S_SCAN_REQ;
                    else                                    cnt_d[i]   = cnt_q[i] - 1'b1;
                end
                S_SCAN_REQ: begin
                    if (!check[i]) state_d[i] = S_IDLE;
                    else if (grant_valid && grant_ch == 1'(i)) begin
                        state_d[i] = S_SCAN;
                        abort_d[i] = 1'b0;
                    end
                end
                S_SCAN: begin
                    if (!check[i]) abort_d[i] = 1'b1;
                    if (scan_last && eng_owner_q == 1'(i)) begin
                        if (abort_q[i] || !check[i]) state_d[i] = S_IDLE;
                        else begin
                            state_d[i] = S_EXPLODE;
                            cnt_d[i]   = CW'(BLAST_FRAMES - 1);
                            mask_d[i]  = final_mask;
                        end
                    end
                end
                S_EXPLODE: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = S_DONE;
                        mask_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                S_DONE:  if (!check[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        eng_active_d = eng_active_q;
        eng_owner_d  = eng_owner_q;
        eng_step_d   = eng_step_q;
        eng_c_d      = eng_c_q;
        eng_blk_d    = eng_blk_q;
        eng_acc_d    = eng_acc_q;
        addr_d       = addr_q;
        rden_d       = 1'b0;
        ptr_d        = ptr_q;
        if (eng_active_q) begin
            if (eng_step_q != 3'd5) eng_step_d = eng_step_q + 3'd1;
            else                    eng_active_d = 1'b0;
            for (int unsigned k = 1; k < 4; k++)
                if (eng_step_q == 3'(k + 1)) eng_acc_d[k] = cap_bit;
            if (eng_step_q <= 3'd3 && !eng_blk_q[eng_step_q + 3'd1]) begin
                addr_d = slot_addr(eng_c_q, eng_step_q + 3'd1);
                rden_d = 1'b1;
            end
        end
        if (grant_valid) begin
            eng_active_d = 1'b1;
            eng_owner_d  = grant_ch;
            eng_step_d   = 3'd0;
            eng_c_d      = centre[grant_ch];
            eng_blk_d    = blk[grant_ch];
            eng_acc_d    = '0;
            addr_d       = centre[grant_ch];
            rden_d       = 1'b1;
            if (req[0] && req[1]) ptr_d = !ptr_q;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i]   <= S_IDLE;
                cnt_q[i]     <= '0;
                mask_q[i]    <= '0;
                abort_q[i]   <= 1'b0;
                code_q[i]    <= '0;
                explode_q[i] <= 1'b0;
            end
            eng_active_q <= 1'b0;
            eng_owner_q  <= 1'b0;
            eng_step_q   <= '0;
            eng_c_q      <= '0;
            eng_blk_q    <= '0;
            eng_acc_q    <= '0;
            addr_q       <= '0;
            rden_q       <= 1'b0;
            ptr_q        <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                mask_q[i]    <= mask_d[i];
                abort_q[i]   <= abort_d[i];
                code_q[i]    <= state_code(state_d[i]);
                explode_q[i] <= (state_d[i] == S_EXPLODE);
            end
            eng_active_q <= eng_active_d;
            eng_owner_q  <= eng_owner_d;
            eng_step_q   <= eng_step_d;
            eng_c_q      <= eng_c_d;
            eng_blk_q    <= eng_blk_d;
            eng_acc_q    <= eng_acc_d;
            addr_q       <= addr_d;
            rden_q       <= rden_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bomb_state0 = code_q[0];
    assign bomb_state1 = code_q[1];
    assign blast_mask0 = mask_q[0];
    assign blast_mask1 = mask_q[1];
    assign explode0    = explode_q[0];
    assign explode1    = explode_q[1];
    assign map_addr    = addr_q;
    assign map_rden    = rden_q;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Randomized bench for bomb_sequencer: expected timelines are derived per scenario from
// drop times, tile positions and the map contents, then compared every cycle.
module tb_bomb_sequencer;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       bomb_check0, bomb_check1;
    logic [9:0] bombX0, bombX1, bombY0, bombY1;
    logic [3:0] map_q = '0;
    logic [3:0] bomb_state0, bomb_state1;
    logic [9:0] map_addr;
    logic       map_rden;
    logic [4:0] blast_mask0, blast_mask1;
    logic       explode0, explode1;

    bomb_sequencer #(
        .FUSE_FRAMES(120), .BLAST_FRAMES(30), .MAP_W(20), .MAP_H(15), .WALL_CODE(4'd1)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .bomb_check0(bomb_check0), .bomb_check1(bomb_check1),
        .bombX0(bombX0), .bombX1(bombX1), .bombY0(bombY0), .bombY1(bombY1),
        .map_q(map_q),
        .bomb_state0(bomb_state0), .bomb_state1(bomb_state1),
        .map_addr(map_addr), .map_rden(map_rden),
        .blast_mask0(blast_mask0), .blast_mask1(blast_mask1),
        .explode0(explode0), .explode1(explode1)
    );

    always #5 frame_clk = ~frame_clk;

    logic [3:0] mem [0:1023];
    always @(posedge frame_clk) if (map_rden) map_q <= mem[map_addr];

    int checks = 0;
    int passes = 0;
    int ptr_m  = 0;
    int s_drop [2];
    bit s_used [2];
    int s_cx   [2];
    int s_cy   [2];
    localparam int NEVER = 1 << 29;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_pix(input int ch, input int x, input int y);
        s_cx[ch] = x / 32;
        s_cy[ch] = y / 32;
        if (ch == 0) begin bombX0 = 10'(x); bombY0 = 10'(y); end
        else         begin bombX1 = 10'(x); bombY1 = 10'(y); end
    endtask

    task automatic set_tile(input int ch, input int cx, input int cy);
        set_pix(ch, cx * 32 + int'($urandom_range(0, 31)), cy * 32 + int'($urandom_range(0, 31)));
    endtask

    function automatic bit open_tile(input int cx, input int cy);
        return mem[cy * 20 + cx] != 4'd1;
    endfunction

    function automatic logic [4:0] exp_mask(input int cx, input int cy);
        logic [4:0] m = 5'b00001;
        if (cx > 0  && open_tile(cx - 1, cy)) m[1] = 1'b1;
        if (cx < 19 && open_tile(cx + 1, cy)) m[2] = 1'b1;
        if (cy > 0  && open_tile(cx, cy - 1)) m[3] = 1'b1;
        if (cy < 14 && open_tile(cx, cy + 1)) m[4] = 1'b1;
        return m;
    endfunction

    function automatic bit reaches(input logic [4:0] m, input int ax, input int ay, input int bx, input int by);
        return (bx == ax && by == ay) || (m[1] && by == ay && bx == ax - 1) || (m[2] && by == ay && bx == ax + 1)
            || (m[3] && bx == ax && by == ay - 1) || (m[4] && bx == ax && by == ay + 1);
    endfunction

    function automatic bit slot_skipped(input int cx, input int cy, input int k);
        return (k == 1 && cx == 0) || (k == 2 && cx == 19) || (k == 3 && cy == 0) || (k == 4 && cy == 14);
    endfunction

    task automatic run_scen(input string name);
        int r [2];
        int g [2];
        logic [4:0] m [2];
        int off [5] = '{0, -1, 1, -20, 20};
        int f, s, e, t, last, rel, k, exp_rd, exp_ad, es, got_st, got_mk, got_ex;
        for (int ch = 0; ch < 2; ch++) begin
            if (!s_used[ch]) s_drop[ch] = NEVER;
            m[ch] = exp_mask(s_cx[ch], s_cy[ch]);
            r[ch] = s_used[ch] ? s_drop[ch] + 120 : NEVER;
            g[ch] = r[ch];
        end
        if (s_used[0] && s_used[1]) begin
            if (r[0] < r[1])      f = 0;
            else if (r[1] < r[0]) f = 1;
            else begin f = ptr_m; ptr_m = 1 - ptr_m; end
            s = 1 - f;
            e = g[f] + 7;
            t = (s_drop[s] > e) ? s_drop[s] : e;
            if (reaches(m[f], s_cx[f], s_cy[f], s_cx[s], s_cy[s]) && t <= e + 29 && t + 1 < r[s]) r[s] = t + 1;
            g[s] = (r[s] > g[f] + 6) ? r[s] : g[f] + 6;
        end
        last = 0;
        for (int ch = 0; ch < 2; ch++) if (s_used[ch] && g[ch] > last) last = g[ch];
        rel = last + 38 + int'($urandom_range(0, 3));
        for (int n = 1; n <= rel; n++) begin
            @(negedge frame_clk);
            bomb_check0 = s_used[0] && n >= s_drop[0] && n < rel;
            bomb_check1 = s_used[1] && n >= s_drop[1] && n < rel;
            @(posedge frame_clk);
            #1;
            exp_rd = 0;
            exp_ad = 0;
            for (int ch = 0; ch < 2; ch++) begin
                if (!s_used[ch] || n < s_drop[ch] || n >= rel) es = 0;
                else if (n < r[ch])      es = 1;
                else if (n < g[ch] + 7)  es = 2;
                else if (n < g[ch] + 37) es = 3;
                else                     es = 15;
                got_st = (ch == 0) ? int'(bomb_state0) : int'(bomb_state1);
                got_mk = (ch == 0) ? int'(blast_mask0) : int'(blast_mask1);
                got_ex = (ch == 0) ? int'(explode0)    : int'(explode1);
                check_eq($sformatf("%s state%0d n=%0d", name, ch, n), got_st, es);
                check_eq($sformatf("%s explode%0d n=%0d", name, ch, n), got_ex, (es == 3) ? 1 : 0);
                check_eq($sformatf("%s mask%0d n=%0d", name, ch, n), got_mk, (es == 3) ? int'(m[ch]) : 0);
                k = n - g[ch] - 1;
                if (s_used[ch] && k >= 0 && k <= 4 && !slot_skipped(s_cx[ch], s_cy[ch], k)) begin
                    exp_rd = 1;
                    exp_ad = s_cy[ch] * 20 + s_cx[ch] + off[k];
                end
            end
            check_eq($sformatf("%s rden n=%0d", name, n), int'(map_rden), exp_rd);
            if (exp_rd == 1) check_eq($sformatf("%s addr n=%0d", name, n), int'(map_addr), exp_ad);
        end
    endtask

    task automatic check_all_reset(input string name);
        check_eq({name, " state0"}, int'(bomb_state0), 0);
        check_eq({name, " state1"}, int'(bomb_state1), 0);
        check_eq({name, " rden"},   int'(map_rden), 0);
        check_eq({name, " addr"},   int'(map_addr), 0);
        check_eq({name, " mask0"},  int'(blast_mask0), 0);
        check_eq({name, " mask1"},  int'(blast_mask1), 0);
        check_eq({name, " explode0"}, int'(explode0), 0);
        check_eq({name, " explode1"}, int'(explode1), 0);
    endtask

    task automatic clear_map();
        for (int a = 0; a < 1024; a++) mem[a] = 4'd0;
    endtask

    initial begin
        int d, sel, dir, nx, ny;
        Reset = 1'b1;
        bomb_check0 = 1'b0;
        bomb_check1 = 1'b0;
        set_pix(0, 0, 0);
        set_pix(1, 0, 0);
        clear_map();
        repeat (2) @(posedge frame_clk);
        #1;
        check_all_reset("reset");
        @(negedge frame_clk);
        Reset = 1'b0;

        // Single bomb on an open map, then with a wall to its right, then in the corner.
        s_used = '{1, 0};
        s_drop = '{1, 0};
        set_pix(0, 100, 100);
        run_scen("open");
        mem[64] = 4'd1;
        run_scen("wallR");
        clear_map();
        set_pix(0, 4, 4);
        run_scen("corner");

        // Simultaneous expiry twice: arbitration alternates between the runs.
        s_used = '{1, 1};
        s_drop = '{3, 3};
        set_tile(0, 2, 7);
        set_tile(1, 15, 9);
        run_scen("tieA");
        run_scen("tieB");

        // Neighbouring bombs: chain on an open map, no chain through a wall.
        s_drop = '{1, 61};
        set_tile(0, 5, 5);
        set_tile(1, 6, 5);
        run_scen("chain");
        mem[106] = 4'd1;
        run_scen("nochain");
        clear_map();

        for (int sc = 0; sc < 30; sc++) begin
            for (int a = 0; a < 300; a++)
                mem[a] = ($urandom_range(0, 9) < 3) ? 4'd1 : 4'($urandom_range(0, 15));
            set_tile(0, ($urandom_range(0, 4) == 0) ? 19 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 19)),
                        ($urandom_range(0, 4) == 0) ? 14 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 14)));
            if ($urandom_range(0, 9) < 4) begin
                dir = int'($urandom_range(0, 3));
                nx = s_cx[0] + ((dir == 0) ? -1 : (dir == 1) ? 1 : 0);
                ny = s_cy[0] + ((dir == 2) ? -1 : (dir == 3) ? 1 : 0);
                if (nx < 0 || nx > 19 || ny < 0 || ny > 14) begin nx = s_cx[0]; ny = s_cy[0]; end
                set_tile(1, nx, ny);
            end else begin
                set_tile(1, int'($urandom_range(0, 19)), int'($urandom_range(0, 14)));
            end
            sel = int'($urandom_range(0, 9));
            s_used = (sel == 0) ? '{1, 0} : (sel == 1) ? '{0, 1} : '{1, 1};
            s_drop[0] = int'($urandom_range(1, 5));
            sel = int'($urandom_range(0, 2));
            d = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 10)) : int'($urandom_range(11, 160));
            s_drop[1] = s_drop[0] + d;
            run_scen($sformatf("rand%0d", sc));
        end

        // Reset in the middle of a scan.
        set_pix(0, 100, 100);
        for (int n = 1; n <= 124; n++) begin
            @(negedge frame_clk);
            bomb_check0 = 1'b1;
            if (n == 124) Reset = 1'b1;
            @(posedge frame_clk);
            #1;
            if (n == 123) begin
                check_eq("midscan state0", int'(bomb_state0), 2);
                check_eq("midscan rden", int'(map_rden), 1);
                check_eq("midscan addr", int'(map_addr), 62);
            end
        end
        check_all_reset("midscan reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        bomb_check0 = 1'b0;
        ptr_m = 0;
        mem[63 - 20] = 4'd1;
        s_used = '{1, 1};
        s_drop = '{2, 2};
        set_pix(1, 300, 200);
        run_scen("postreset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
